// File: rtl/bt_seq_alu.sv
// Sequential balanced-ternary ALU: single-cycle ADD/SUB/NEG and an N-cycle
// shift-add MUL, with valid/ready handshakes on the operand and result sides.
module bt_seq_alu #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     op,
  input  logic [2*N-1:0] a,
  input  logic [2*N-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*N-1:0] result,
  output logic           err
);

  localparam int RW = 4 * N;
  localparam int CW = $clog2(N);
  localparam logic [RW-1:0] ZERO = {(2 * N){2'b11}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_NEG = 2'b11} op_t;

  function automatic logic signed [2:0] trit_val(input logic [1:0] t);
    case (t)
      2'b01:   return -3'sd1;
      2'b10:   return 3'sd1;
      default: return 3'sd0;
    endcase
  endfunction

  // Returns {carry, sum} as trit codes for x + y + c.
  function automatic logic [3:0] bt_fa(input logic [1:0] x, input logic [1:0] y,
                                       input logic [1:0] c);
    logic signed [2:0] s;
    s = trit_val(x) + trit_val(y) + trit_val(c);
    case (s)
      -3'sd3:  return {2'b01, 2'b11};
      -3'sd2:  return {2'b01, 2'b10};
      -3'sd1:  return {2'b11, 2'b01};
      3'sd1:   return {2'b11, 2'b10};
      3'sd2:   return {2'b10, 2'b01};
      3'sd3:   return {2'b10, 2'b11};
      default: return {2'b11, 2'b11};
    endcase
  endfunction

  // 2N-trit ripple adder; the carry out of the top trit is dropped.
  function automatic logic [RW-1:0] bt_add(input logic [RW-1:0] x, input logic [RW-1:0] y);
    logic [RW-1:0] r;
    logic [1:0]    c;
    logic [3:0]    fa;
    r = ZERO;
    c = 2'b11;
    for (int k = 0; k < 2 * N; k++) begin
      fa         = bt_fa(x[2*k +: 2], y[2*k +: 2], c);
      r[2*k +: 2] = fa[1:0];
      c          = fa[3:2];
    end
    return r;
  endfunction

  function automatic logic [RW-1:0] bt_neg(input logic [RW-1:0] x);
    logic [RW-1:0] r;
    for (int k = 0; k < 2 * N; k++) r[2*k +: 2] = {x[2*k], x[2*k+1]};
    return r;
  endfunction

  function automatic logic [RW-1:0] bt_ext(input logic [2*N-1:0] v);
    return {{N{2'b11}}, v};
  endfunction

  function automatic logic has_illegal(input logic [2*N-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < N; k++) bad = bad | (v[2*k +: 2] == 2'b00);
    return bad;
  endfunction

  state_t         state_q, state_d;
  logic [RW-1:0]  result_q, result_d;
  logic           err_q, err_d;
  logic [RW-1:0]  acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] a_q, a_d, b_q, b_d;

  logic [1:0]     b_trit;
  logic [RW-1:0]  a_ext, pp, pp_sh, acc_sum, op_res;
  logic           op_bad;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign err       = err_q;

  // Multiplier datapath: select -a / 0 / +a, shift by cnt trits padding with zero trits.
  always_comb begin
    a_ext   = bt_ext(a_q);
    b_trit  = b_q[{cnt_q, 1'b0} +: 2];
    pp      = (b_trit == 2'b01) ? bt_neg(a_ext) : (b_trit == 2'b10) ? a_ext : ZERO;
    pp_sh   = (pp << {cnt_q, 1'b0}) | ~({RW{1'b1}} << {cnt_q, 1'b0});
    acc_sum = bt_add(acc_q, pp_sh);
  end

  always_comb begin
    op_bad = has_illegal(a) | ((op_t'(op) != OP_NEG) & has_illegal(b));
    case (op_t'(op))
      OP_ADD:  op_res = bt_add(bt_ext(a), bt_ext(b));
      OP_SUB:  op_res = bt_add(bt_ext(a), bt_neg(bt_ext(b)));
      OP_NEG:  op_res = bt_neg(bt_ext(a));
      default: op_res = ZERO;
    endcase
  end

  always_comb begin
    // NOTE: every next-state signal takes its held value first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    result_d = result_q;
    err_d    = err_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_DONE;
          if (op_bad) begin
            result_d = ZERO;
            err_d    = 1'b1;
          end else if (op_t'(op) == OP_MUL) begin
            state_d  = S_CALC;
            a_d      = a;
            b_d      = b;
            acc_d    = ZERO;
            cnt_d    = '0;
            result_d = ZERO;
            err_d    = 1'b0;
          end else begin
            result_d = op_res;
            err_d    = 1'b0;
          end
        end
      end
      S_CALC: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          state_d  = S_DONE;
          result_d = acc_sum;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= ZERO;
      err_q    <= 1'b0;
      acc_q    <= ZERO;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: latched operands carry no reset; they are always loaded before CALC reads them.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

endmodule

// File: tb/tb_bt_seq_alu.sv
// Directed-vector bench for bt_seq_alu (N=4) with hand-computed trit results.
module tb_bt_seq_alu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        err;

  int n_vec = 0;
  int n_bad = 0;

  bt_seq_alu #(.N(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge with the DUT in IDLE.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [7:0] aa,
                        input logic [7:0] bb, input logic [15:0] exp_r, input logic exp_e,
                        input int exp_lat, input int hold);
    int lat;
    logic [15:0] r0;
    check({tag, ".rdy"}, 32'(in_ready), 32'd1);
    op = o; a = aa; b = bb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~aa; b = ~bb; op = ~o;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".res"}, 32'(result), 32'(exp_r));
    check({tag, ".err"}, 32'(err), 32'(exp_e));
    r0 = result;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; op = 2'b00; a = 8'hAA; b = 8'hAA;
      @(posedge clk); #1;
      check({tag, ".hold_v"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_r"}, 32'(result), 32'(r0));
      check({tag, ".hold_e"}, 32'(err), 32'(exp_e));
      check({tag, ".hold_rdy"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".drop_v"}, 32'(out_valid), 32'd0);
    check({tag, ".idle"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; a = 8'h00; b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst.rdy", 32'(in_ready), 32'd1);
    check("rst.v", 32'(out_valid), 32'd0);
    check("rst.res", 32'(result), 32'hFFFF);
    check("rst.err", 32'(err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // ADD/SUB/NEG, latency 1
    run_op("add40", 2'b00, 8'hAA, 8'hAA, 16'hFEFD, 1'b0, 1, 0);
    run_op("addm40", 2'b00, 8'h55, 8'h55, 16'hFDFE, 1'b0, 1, 0);
    run_op("add_p1m1", 2'b00, 8'hFE, 8'hFD, 16'hFFFF, 1'b0, 1, 0);
    run_op("sub5", 2'b01, 8'hE5, 8'hE5, 16'hFFFF, 1'b0, 1, 0);
    run_op("sub_0m1", 2'b01, 8'hFF, 8'hFE, 16'hFFFD, 1'b0, 1, 0);
    run_op("neg_m1", 2'b11, 8'hFD, 8'hFD, 16'hFFFE, 1'b0, 1, 0);
    run_op("neg_bbad", 2'b11, 8'hFD, 8'h00, 16'hFFFE, 1'b0, 1, 0);

    // MUL, latency N+1, with backpressure on the first
    run_op("mul40", 2'b10, 8'hAA, 8'hAA, 16'h9966, 1'b0, 5, 3);
    run_op("mulm40", 2'b10, 8'h55, 8'hAA, 16'h6699, 1'b0, 5, 0);
    run_op("mul_1_27", 2'b10, 8'hFE, 8'hBF, 16'hFFBF, 1'b0, 5, 0);
    run_op("mul_1_m1", 2'b10, 8'hFE, 8'hFD, 16'hFFFD, 1'b0, 5, 0);

    // Illegal trit codes
    run_op("add_bad", 2'b00, 8'hAA, 8'hCF, 16'hFFFF, 1'b1, 1, 2);
    run_op("mul_bad", 2'b10, 8'hFC, 8'hAA, 16'hFFFF, 1'b1, 1, 0);

    // Reset in the middle of a multiply (cnt == 2)
    op = 2'b10; a = 8'hAA; b = 8'hAA; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst.rdy", 32'(in_ready), 32'd1);
    check("mrst.v", 32'(out_valid), 32'd0);
    check("mrst.res", 32'(result), 32'hFFFF);
    check("mrst.err", 32'(err), 32'd0);
    run_op("add_after", 2'b00, 8'hAA, 8'hAA, 16'hFEFD, 1'b0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
